// File: rtl/conv_alu_pipe_pkg.sv
// conv_alu_pipe_pkg
// Purpose: defaults and helper functions shared by the convolution ALU pipeline.
//   - *_DEF parameters give the default geometry. With the defaults, a pixel is
//     12'hRGB and the window is 5x5.
//   - acc_width() derives the signed accumulator width from the geometry.
//   - tap_lsb() maps a tap index to the LSB of its slice in a packed vector.
//     Tap 0 sits in the MSBs and taps are stored row-major.
package conv_alu_pipe_pkg;

  localparam int CH_W_DEF  = 4;
  localparam int NCH_DEF   = 3;
  localparam int KSIZE_DEF = 5;
  localparam int KW_DEF    = 8;
  localparam int SH_W_DEF  = 4;
  localparam int AW_DEF    = 17;

  // Signed accumulator width. It holds the sum of KSIZE*KSIZE products of
  // (CH_W+1)-bit signed pixels by KW-bit signed coefficients with no overflow.
  function automatic int acc_width(input int ch_w, input int kw, input int ksize);
    return ch_w + kw + $clog2(ksize * ksize) + 1;
  endfunction

  // LSB position of a tap's slice when tap 0 occupies the MSBs.
  function automatic int tap_lsb(input int tap, input int ntap, input int tap_w);
    return (ntap - 1 - tap) * tap_w;
  endfunction

endpackage

// File: rtl/conv_mac_tree.sv
// conv_mac_tree
// Purpose: handles the multiply stage (S1) and the adder tree (S2) for one colour channel.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   en       : pipeline advance. While it is low, both stages hold.
//   pix      : this channel's KSIZE*KSIZE pixels, tap 0 in the MSBs
//   kern     : signed coefficients in the same tap order
//   acc      : registered signed sum of the products, ACC_W bits (S2 output)
module conv_mac_tree
  import conv_alu_pipe_pkg::*;
#(
  parameter int CH_W  = CH_W_DEF,
  parameter int KSIZE = KSIZE_DEF,
  parameter int KW    = KW_DEF,
  parameter int ACC_W = acc_width(CH_W_DEF, KW_DEF, KSIZE_DEF)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [KSIZE*KSIZE*CH_W-1:0] pix,
  input  logic [KSIZE*KSIZE*KW-1:0]   kern,
  output logic signed [ACC_W-1:0]   acc
);

  localparam int NTAP = KSIZE * KSIZE;
  localparam int PW   = CH_W + KW + 1;

  logic signed [PW-1:0]    prod_d [NTAP];
  logic signed [PW-1:0]    prod_q [NTAP];
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] acc_q;

  // Per-tap products. The pixel is zero-extended by one bit so that it reads as
  // a non-negative signed value.
  always_comb begin
    for (int t = 0; t < NTAP; t++) begin
      prod_d[t] = PW'($signed({1'b0, pix[tap_lsb(t, NTAP, CH_W) +: CH_W]}))
                * PW'($signed(kern[tap_lsb(t, NTAP, KW) +: KW]));
    end
  end

  // Adder tree over the registered products, with each product sign-extended to ACC_W.
  always_comb begin
    acc_d = '0;
    for (int t = 0; t < NTAP; t++) begin
      acc_d = acc_d + ACC_W'(prod_q[t]);
    end
  end

  // S1/S2 stage registers. Both stages hold while the pipeline is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < NTAP; t++) begin
        prod_q[t] <= '0;
      end
      acc_q <= '0;
    end else if (en) begin
      prod_q <= prod_d;
      acc_q  <= acc_d;
    end else begin
      prod_q <= prod_q;
      acc_q  <= acc_q;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/conv_alu_pipe.sv
// conv_alu_pipe
// Purpose: 3-stage pipelined signed KSIZE x KSIZE convolution over NCH-channel
//   pixels. Each channel's result is normalised by an arithmetic right shift,
//   optionally after taking the absolute value, and then clamped.
//   The read address travels with the beat and comes out as the write address.
// Ports:
//   clk, rst            : clock and asynchronous active-high reset
//   in_valid / in_ready : input handshake. in_ready is the combinational advance signal.
//   din, kernel         : window pixels and signed coefficients, tap 0 in the MSBs
//   shift, abs_en       : per-beat normalisation config, sampled on acceptance
//   raddr               : address of the window centre
//   out_valid/out_ready : output handshake
//   dout, waddr         : filtered pixel and the carried address (registered)
module conv_alu_pipe
  import conv_alu_pipe_pkg::*;
#(
  parameter int CH_W  = CH_W_DEF,
  parameter int NCH   = NCH_DEF,
  parameter int KSIZE = KSIZE_DEF,
  parameter int KW    = KW_DEF,
  parameter int SH_W  = SH_W_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [KSIZE*KSIZE*NCH*CH_W-1:0] din,
  input  logic [KSIZE*KSIZE*KW-1:0]       kernel,
  input  logic [SH_W-1:0]                 shift,
  input  logic                            abs_en,
  input  logic [AW-1:0]                   raddr,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NCH*CH_W-1:0]             dout,
  output logic [AW-1:0]                   waddr
);

  localparam int NTAP  = KSIZE * KSIZE;
  localparam int ACC_W = acc_width(CH_W, KW, KSIZE);
  // Upper clamp bound, 2^CH_W-1, at the width of the normalised value.
  localparam logic signed [ACC_W:0] PIX_MAX = {{(ACC_W + 1 - CH_W){1'b0}}, {CH_W{1'b1}}};

  logic advance;
  logic signed [ACC_W-1:0] acc_s2 [NCH];
  logic [NCH*CH_W-1:0] norm_s;

  logic v1_d, v1_q, v2_d, v2_q, out_valid_d, out_valid_q;
  logic [SH_W-1:0] shift1_d, shift1_q, shift2_d, shift2_q;
  logic abs1_d, abs1_q, abs2_d, abs2_q;
  logic [AW-1:0] addr1_d, addr1_q, addr2_d, addr2_q, waddr_d, waddr_q;
  logic [NCH*CH_W-1:0] dout_d, dout_q;

  // The whole pipeline moves together. It stalls only while the output holds a
  // beat that downstream is refusing.
  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [NTAP*CH_W-1:0] pix_c;

    // Pull channel c of every tap out of the window, keeping the tap order.
    always_comb begin
      pix_c = '0;
      for (int t = 0; t < NTAP; t++) begin
        pix_c[tap_lsb(t, NTAP, CH_W) +: CH_W] = din[tap_lsb(t, NTAP, NCH*CH_W) + c*CH_W +: CH_W];
      end
    end

    conv_mac_tree #(
      .CH_W  (CH_W),
      .KSIZE (KSIZE),
      .KW    (KW),
      .ACC_W (ACC_W)
    ) u_mac (
      .clk  (clk),
      .rst  (rst),
      .en   (advance),
      .pix  (pix_c),
      .kern (kernel),
      .acc  (acc_s2[c])
    );
  end

  // S3 normalise. |acc| is formed one bit wider, so the most negative
  // accumulator does not wrap. The arithmetic shift floors, and a negative
  // result clamps to 0.
  always_comb begin
    logic signed [ACC_W:0] v;
    norm_s = '0;
    for (int c = 0; c < NCH; c++) begin
      v = (ACC_W + 1)'(acc_s2[c]);
      if (abs2_q && v[ACC_W]) begin
        v = -v;
      end else begin
        v = v;
      end
      v = v >>> shift2_q;
      if (v[ACC_W]) begin
        norm_s[c*CH_W +: CH_W] = '0;
      end else if (v > PIX_MAX) begin
        norm_s[c*CH_W +: CH_W] = '1;
      end else begin
        norm_s[c*CH_W +: CH_W] = v[CH_W-1:0];
      end
    end
  end

  // Valid chain and side-band pipeline. On an input bubble, dout and waddr keep their last values.
  always_comb begin
    v1_d        = v1_q;
    v2_d        = v2_q;
    out_valid_d = out_valid_q;
    shift1_d    = shift1_q;
    shift2_d    = shift2_q;
    abs1_d      = abs1_q;
    abs2_d      = abs2_q;
    addr1_d     = addr1_q;
    addr2_d     = addr2_q;
    dout_d      = dout_q;
    waddr_d     = waddr_q;
    if (advance) begin
      v1_d        = in_valid;
      shift1_d    = shift;
      abs1_d      = abs_en;
      addr1_d     = raddr;
      v2_d        = v1_q;
      shift2_d    = shift1_q;
      abs2_d      = abs1_q;
      addr2_d     = addr1_q;
      out_valid_d = v2_q;
      if (v2_q) begin
        dout_d  = norm_s;
        waddr_d = addr2_q;
      end else begin
        dout_d  = dout_q;
        waddr_d = waddr_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      shift1_q    <= '0;
      shift2_q    <= '0;
      abs1_q      <= 1'b0;
      abs2_q      <= 1'b0;
      addr1_q     <= '0;
      addr2_q     <= '0;
      dout_q      <= '0;
      waddr_q     <= '0;
    end else begin
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      out_valid_q <= out_valid_d;
      shift1_q    <= shift1_d;
      shift2_q    <= shift2_d;
      abs1_q      <= abs1_d;
      abs2_q      <= abs2_d;
      addr1_q     <= addr1_d;
      addr2_q     <= addr2_d;
      dout_q      <= dout_d;
      waddr_q     <= waddr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign waddr     = waddr_q;

endmodule

// File: tb/tb_conv_alu_pipe.sv
// tb_conv_alu_pipe
// Purpose: scoreboard bench for conv_alu_pipe at the default geometry
//   (a 5x5 window of 12'hRGB pixels with 8-bit coefficients).
//   Stimulus pushes the hand-computed result when a beat is accepted.
//   A negedge monitor pops and compares each result the DUT delivers.
module tb_conv_alu_pipe;

  localparam int NTAP = 25;
  localparam int CTR  = 12;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [299:0] din;
  logic [199:0] kernel;
  logic [3:0]   shift;
  logic         abs_en;
  logic [16:0]  raddr;
  logic         out_valid;
  logic         out_ready;
  logic [11:0]  dout;
  logic [16:0]  waddr;

  typedef struct {
    logic [11:0] pix;
    logic [16:0] addr;
    int          acc_cyc;
    bit          chk_lat;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [11:0] last_dout = 12'h000;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  conv_alu_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .kernel    (kernel),
    .shift     (shift),
    .abs_en    (abs_en),
    .raddr     (raddr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .waddr     (waddr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [299:0] mk_din(input logic [11:0] cpix, input logic [11:0] opix);
    logic [299:0] d;
    for (int t = 0; t < NTAP; t++) d[(NTAP-1-t)*12 +: 12] = (t == CTR) ? cpix : opix;
    return d;
  endfunction

  function automatic logic [199:0] mk_kern(input logic [7:0] ck, input logic [7:0] ok);
    logic [199:0] k;
    for (int t = 0; t < NTAP; t++) k[(NTAP-1-t)*8 +: 8] = (t == CTR) ? ck : ok;
    return k;
  endfunction

  // Called just after a rising edge. Offers one beat, waits (bounded) for
  // acceptance, then pushes the expected result. Returns just after the
  // accepting edge.
  task automatic send(input logic [11:0] cpix, input logic [11:0] opix,
                      input logic [7:0] ck, input logic [7:0] ok,
                      input logic [3:0] sh, input logic ab, input logic [16:0] ra,
                      input logic [11:0] exp_pix, input bit lat);
    int n = 0;
    exp_t e;
    din      = mk_din(cpix, opix);
    kernel   = mk_kern(ck, ok);
    shift    = sh;
    abs_en   = ab;
    raddr    = ra;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: raddr %0d never accepted (in_ready=%0b, required 1)", ra, in_ready);
      @(posedge clk);
      #1;
    end else begin
      @(posedge clk);
      #1;
      e.pix = exp_pix; e.addr = ra; e.acc_cyc = cyc; e.chk_lat = lat;
      sb.push_back(e);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: one result leaves on every rising edge where out_valid && out_ready.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: dout %0h waddr %0d with no beat outstanding", dout, waddr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("dout", 32'(dout), 32'(e.pix));
        check("waddr", 32'(waddr), 32'(e.addr));
        // Result shows after the third rising edge, counting the accepting edge.
        if (e.chk_lat) check("latency", 32'(cyc - e.acc_cyc), 32'd2);
        last_dout = e.pix;
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    din = '0; kernel = '0; shift = 4'd0; abs_en = 1'b0; raddr = 17'd0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_waddr", 32'(waddr), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Identity, box, negative/abs, saturation, shift clamp
    send(12'h022, 12'h000, 8'sd1,   8'sd0,   4'd0,  1'b0, 17'd1, 12'h022, 1'b1);
    send(12'hFFF, 12'hFFF, 8'sd1,   8'sd1,   4'd5,  1'b0, 17'd2, 12'hBBB, 1'b0);
    send(12'hFFF, 12'hFFF, 8'sd1,   8'sd1,   4'd4,  1'b0, 17'd3, 12'hFFF, 1'b0);
    send(12'h123, 12'h000, -8'sd1,  8'sd0,   4'd0,  1'b0, 17'd4, 12'h000, 1'b0);
    send(12'h123, 12'h000, -8'sd1,  8'sd0,   4'd0,  1'b1, 17'd5, 12'h123, 1'b0);
    send(12'hF0F, 12'h000, 8'sd127, 8'sd0,   4'd0,  1'b0, 17'd6, 12'hF0F, 1'b0);
    send(12'hF0F, 12'h000, 8'sd127, 8'sd0,   4'd11, 1'b0, 17'd7, 12'h000, 1'b0);
    send(12'hFFF, 12'hFFF, -8'sd1,  -8'sd1,  4'd5,  1'b1, 17'd8, 12'hBBB, 1'b0);
    send(12'hFFF, 12'hFFF, -8'sd1,  -8'sd1,  4'd5,  1'b0, 17'd9, 12'h000, 1'b0);
    send(12'h123, 12'h000, 8'sd2,   8'sd0,   4'd1,  1'b0, 17'd20, 12'h123, 1'b0);
    wait_drain();
    repeat (2) @(posedge clk);
    #1;
    check("bubble_out_valid", 32'(out_valid), 32'd0);
    check("bubble_dout_hold", 32'(dout), 32'h123);
    check("bubble_waddr_hold", 32'(waddr), 32'd20);

    // Backpressure: out_ready is held low for 5 cycles while 4 beats stream in
    fork
      begin
        send(12'h321, 12'h000, 8'sd1, 8'sd0, 4'd0, 1'b0, 17'd10, 12'h321, 1'b0);
        send(12'h321, 12'h000, 8'sd2, 8'sd0, 4'd0, 1'b0, 17'd11, 12'h642, 1'b0);
        send(12'h321, 12'h000, 8'sd3, 8'sd0, 4'd0, 1'b0, 17'd12, 12'h963, 1'b0);
        send(12'h321, 12'h000, 8'sd4, 8'sd0, 4'd0, 1'b0, 17'd13, 12'hC84, 1'b0);
      end
      begin
        out_ready = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("bp_in_ready_full", 32'(in_ready), 32'd0);
        check("bp_out_valid_full", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();
    check("bp_drained_out_valid", 32'(out_valid), 32'd0);
    check("bp_last_dout", 32'(last_dout), 32'hC84);

    // Reset while three beats are in flight
    send(12'h111, 12'h000, 8'sd1, 8'sd0, 4'd0, 1'b0, 17'd30, 12'h111, 1'b0);
    send(12'h222, 12'h000, 8'sd1, 8'sd0, 4'd0, 1'b0, 17'd31, 12'h222, 1'b0);
    send(12'h333, 12'h000, 8'sd1, 8'sd0, 4'd0, 1'b0, 17'd32, 12'h333, 1'b0);
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #1;
    rst = 1'b1;
    sb.delete();
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_dout", 32'(dout), 32'd0);
    check("mid_rst_waddr", 32'(waddr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(12'h0A5, 12'h000, 8'sd1, 8'sd0, 4'd0, 1'b0, 17'd77, 12'h0A5, 1'b1);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
